// File: rtl/reg_file_pkg.sv
// Shared definitions for the Salamander operand register file:
// clear-sequencer state encoding and default geometry used by the CPU top.
package reg_file_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: range check, hardwired-zero mask, write forwarding
// and the output data/valid registers.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              en,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              oor
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic              in_range;
    logic              zero_hit;
    logic              fwd_hit;
    logic [DATA_W-1:0] rdata_next;
    logic [DATA_W-1:0] rdata_reg;
    logic              rvalid_reg;

    assign in_range = ({1'b0, raddr} < DEPTH_X);
    assign zero_hit = ZERO_REG && (raddr == '0);
    // wr_en is already qualified (in range, not the zero entry, not busy)
    assign fwd_hit  = BYPASS && wr_en && (waddr == raddr);

    always_comb begin
        rdata_next = arr_data;
        if (!in_range || zero_hit) begin
            rdata_next = '0;
        end else if (fwd_hit) begin
            rdata_next = wdata;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= en;
            if (en) begin
                rdata_reg <= rdata_next;
            end
        end
    end

    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;
    assign oor    = en && !in_range;

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with a sequenced clear engine and a sticky
// out-of-range address error flag.
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              CLR,
    output logic              BUSY,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              RE_A,
    input  logic [ADDR_W-1:0] RADDR_A,
    output logic [DATA_W-1:0] RDATA_A,
    output logic              RVALID_A,
    input  logic              RE_B,
    input  logic [ADDR_W-1:0] RADDR_B,
    output logic [DATA_W-1:0] RDATA_B,
    output logic              RVALID_B,
    output logic              ERR
);

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    clr_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              err_reg, err_next;

    logic              busy;
    logic              clr_accept;
    logic              waddr_ok;
    logic              wr_ok;
    logic              wr_oor;
    logic              rd_en_a, rd_en_b;
    logic              oor_a, oor_b;
    logic [DATA_W-1:0] arr_a, arr_b;

    logic [DEPTH-1:0][DATA_W-1:0] mem_flat;

    assign busy       = (state_reg == CLEAR);
    assign clr_accept = (state_reg == IDLE) && CLR;
    assign waddr_ok   = ({1'b0, WADDR} < DEPTH_X);
    assign wr_ok      = WE && !busy && waddr_ok && !(ZERO_REG && (WADDR == '0));
    assign wr_oor     = WE && !busy && !waddr_ok;
    assign rd_en_a    = RE_A && !busy;
    assign rd_en_b    = RE_B && !busy;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (CLR) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            CLEAR: begin
                // Stop on the last real entry so the pointer never passes DEPTH-1
                if (ptr_reg == LAST_IDX) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr_reg + ADDR_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        err_next = clr_accept ? 1'b0 : err_reg;
        if (oor_a || oor_b || wr_oor) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            err_reg   <= err_next;
        end
    end

    // Storage is flop-based: every entry must be zero the instant reset asserts.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            logic [DATA_W-1:0] entry_reg;

            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    entry_reg <= '0;
                end else if (busy && (ptr_reg == IDX)) begin
                    entry_reg <= '0;
                end else if (wr_ok && (WADDR == IDX)) begin
                    entry_reg <= WDATA;
                end
            end

            assign mem_flat[gi] = entry_reg;
        end
    endgenerate

    // Out-of-range indices are masked to zero inside the read port
    assign arr_a = mem_flat[RADDR_A];
    assign arr_b = mem_flat[RADDR_B];

    reg_file_rd_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_rd_a (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .en       (rd_en_a),
        .raddr    (RADDR_A),
        .arr_data (arr_a),
        .wr_en    (wr_ok),
        .waddr    (WADDR),
        .wdata    (WDATA),
        .rdata    (RDATA_A),
        .rvalid   (RVALID_A),
        .oor      (oor_a)
    );

    reg_file_rd_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_rd_b (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .en       (rd_en_b),
        .raddr    (RADDR_B),
        .arr_data (arr_b),
        .wr_en    (wr_ok),
        .waddr    (WADDR),
        .wdata    (WDATA),
        .rdata    (RDATA_B),
        .rvalid   (RVALID_B),
        .oor      (oor_b)
    );

    assign BUSY = busy;
    assign ERR  = err_reg;

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
Parametrised successor to the single-port 8-bit register file: one write port and two independent registered read ports, for operand fetch in the Salamander datapath.
- Configurable data width, depth, write-to-read bypass and an optional hardwired-zero entry 0.
- Sequenced clear engine that zeroes the array without a reset.
- Sticky error flag for out-of-range addresses.

Parameters:
DATA_W, 8, data width in bits
DEPTH, 4, number of entries (>=2, need not be a power of two)
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
BYPASS, 1, 1 = same-cycle write forwarded to read output; 0 = read returns pre-write contents
ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes

Ports:
CLK  input  1  clock, all state on rising edge
RSTN  input  1  reset, asynchronous, active-low
CLR  input  1  single-cycle pulse: start array clear
BUSY  output  1  clear sequence in progress
WE  input  1  write enable
WADDR  input  ADDR_W  write address
WDATA  input  DATA_W  write data
RE_A  input  1  read enable, port A
RADDR_A  input  ADDR_W  read address, port A
RDATA_A  output  DATA_W  registered read data, port A
RVALID_A  output  1  RDATA_A updated this cycle
RE_B  input  1  read enable, port B
RADDR_B  input  ADDR_W  read address, port B
RDATA_B  output  DATA_W  registered read data, port B
RVALID_B  output  1  RDATA_B updated this cycle
ERR  output  1  sticky: out-of-range address used

Behaviour:
- Reset (RSTN low, async):
  - All entries 0.
  - RDATA_A/B = 0, RVALID_A/B = 0, BUSY = 0, ERR = 0.
  - FSM in IDLE, clear pointer = 0.
- Write: on the edge with WE=1 and not BUSY, entry[WADDR] <= WDATA.
  - Ignored if WADDR >= DEPTH, or if ZERO_REG=1 and WADDR=0.
- Read latency: 1 cycle.
  - RE_x=1 at edge N -> RDATA_x, RVALID_x=1 valid after edge N.
  - RE_x=0 -> RVALID_x=0 next cycle; RDATA_x holds its last value.
- Read-during-write to the same address (WE and RE_x both valid):
  - BYPASS=1: RDATA_x = WDATA.
  - BYPASS=0: RDATA_x = old entry contents.
  - Both ports may hit simultaneously; each follows the same rule.
- ZERO_REG=1, read of address 0: returns 0 regardless of writes or bypass.
- Out-of-range address (RADDR_x or WADDR >= DEPTH, only when the port's enable is 1):
  - Out-of-range read returns 0 with RVALID=1.
  - ERR set next edge; it stays set until reset or CLR acceptance.
- Clear FSM, states IDLE and CLEAR:
  - IDLE + CLR=1: go to CLEAR, pointer=0, BUSY=1 next cycle, ERR cleared.
  - CLEAR: entry[pointer] <= 0 each cycle, pointer++.
  - Leave CLEAR after writing entry DEPTH-1: back to IDLE, BUSY=0.
  - BUSY is high for exactly DEPTH cycles.
  - CLR while BUSY: ignored; no restart.
  - While BUSY: WE ignored, RE_x ignored (RVALID_x=0), RDATA_x hold.
  - WE/RE in the same cycle as CLR acceptance are still serviced normally; a write accepted there is overwritten by the clear.
- Async reset mid-clear aborts the sequence immediately; the array ends up zero anyway.
- Pointer width is ADDR_W; it never wraps past DEPTH-1.

Decomposition:
- Package reg_file_pkg:
  - Clear-FSM state enum typedef (IDLE, CLEAR).
  - Default DATA_W/DEPTH constants, shared with the CPU top.
- One sub-module, reg_file_rd_port: a read port with bypass mux, zero-reg mask, range check and output register.
  - Instantiated twice; it receives the array read value plus write-port signals.

Test Plan (DATA_W=8, DEPTH=4, BYPASS=1, ZERO_REG=0 unless stated):
- Reset, then read A=0..3 -> RDATA_A=0x00 with RVALID_A=1 one cycle after each RE_A; ERR=0, BUSY=0.
- Write 0xA5 to 2, then RE_A addr 2 and RE_B addr 2 in the same cycle -> both RDATA=0xA5 next cycle.
- Same-cycle WE addr 1 = 0x3C with RE_A addr 1:
  - BYPASS=1 -> RDATA_A=0x3C.
  - Rerun with BYPASS=0 and prior value 0x11 -> RDATA_A=0x11, then 0x3C on the following read.
- Fill 0x10..0x13, pulse CLR -> BUSY high for exactly 4 cycles; WE 0xFF to 0 during BUSY is ignored; afterwards all reads = 0x00.
- DEPTH=3: RE_A addr 3 -> RDATA_A=0x00, RVALID_A=1, ERR=1 and stays 1; WE addr 3 changes nothing; CLR clears ERR.
- ZERO_REG=1: write 0x77 to 0 -> read 0 = 0x00 (also under bypass). Separately, assert RSTN low mid-clear -> all outputs 0 immediately, FSM IDLE.
